// File: rtl/knights_uart_pkg.sv
// Shared definitions for the KnightsTour remote command UART link.
// Holds the default baud divider, the standard acknowledge response and the FSM state types.
package knights_uart_pkg;

    localparam int         BAUD_DIV_DFLT = 2604;
    localparam int         BYTE_TO_DFLT  = 64;
    localparam logic [7:0] RESP_ACK      = 8'hA5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic       {WAIT_HI, WAIT_LO}        asm_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART 8N1 serializer: frames a latched byte as start, d0..d7, stop at BAUD_DIV clocks per bit.
// tx_done is sticky and only clears when a new frame is accepted.
module uart_tx
    import knights_uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          busy_q, busy_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          tx_done_q, tx_done_d;

    // The stop bit rides in the top of the shift register so every bit after the
    // start bit comes out of shift_q[0]; bit_cnt 9 marks the end of the stop bit.
    always_comb begin
        busy_d     = busy_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        tx_done_d  = tx_done_q;
        if (!busy_q) begin
            if (trmt) begin
                busy_d     = 1'b1;
                tx_d       = 1'b0;
                shift_d    = {1'b1, tx_data};
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_done_d  = 1'b0;
            end
        end else if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_d = '0;
            if (bit_cnt_q == 4'd9) begin
                busy_d    = 1'b0;
                tx_done_d = 1'b1;
                tx_d      = 1'b1;
            end else begin
                tx_d      = shift_q[0];
                shift_d   = {1'b1, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else begin
            baud_cnt_d = baud_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '1;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX      = tx_q;
    assign tx_done = tx_done_q;

endmodule

// File: rtl/cmd_uart_responder.sv
// Robot-side end of the remote command link: receives byte pairs into 16-bit commands
// and sends single response bytes back, with RX and TX running independently.
module cmd_uart_responder
    import knights_uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DFLT,
    parameter int BYTE_TO  = BYTE_TO_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done,
    output logic        frame_err
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam int            TO_W      = (BYTE_TO == 0) ? 1 : $clog2(BYTE_TO * BAUD_DIV + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BYTE_TO * BAUD_DIV - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;
    logic          rx_prev_q, rx_prev_d;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          rx_done_q, rx_done_d;

    asm_state_t      asm_state_q, asm_state_d;
    logic [7:0]      hi_byte_q, hi_byte_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic rx_start;
    logic byte_ok;

    assign rx_start  = (rx_state_q == IDLE) && rx_prev_q && !rx_sync_q;
    assign byte_ok   = rx_done_q && shift_q[8];
    assign frame_err = rx_done_q && !shift_q[8];

    // Receive engine. The stop bit is shifted in with the data, so one cycle after
    // the stop sample shift_q holds {stop, d7..d0} and the result is judged there.
    always_comb begin
        rx_meta_d  = RX;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        rx_state_d = rx_state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_done_d  = 1'b0;
        case (rx_state_q)
            IDLE: begin
                if (rx_start) begin
                    rx_state_d = START;
                    baud_cnt_d = '0;
                end
            end
            START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    rx_state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_sync_q, shift_q[8:1]};
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_sync_q, shift_q[8:1]};
                    rx_done_d  = 1'b1;
                    rx_state_d = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_ONE;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // Pair assembler. A set of cmd_rdy is written last so it beats a same-cycle clear;
    // the low-byte timeout only runs while the receiver is idle between frames.
    always_comb begin
        asm_state_d = asm_state_q;
        hi_byte_d   = hi_byte_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        to_cnt_d    = to_cnt_q;
        if (clr_cmd_rdy || (rx_start && asm_state_q == WAIT_HI)) begin
            cmd_rdy_d = 1'b0;
        end
        case (asm_state_q)
            WAIT_HI: begin
                if (byte_ok) begin
                    hi_byte_d   = shift_q[7:0];
                    to_cnt_d    = '0;
                    asm_state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (byte_ok) begin
                    cmd_d       = {hi_byte_q, shift_q[7:0]};
                    cmd_rdy_d   = 1'b1;
                    asm_state_d = WAIT_HI;
                end else if (BYTE_TO != 0 && rx_state_q == IDLE && !rx_start) begin
                    if (to_cnt_q == TO_LAST) begin
                        asm_state_d = WAIT_HI;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_ONE;
                    end
                end
            end
            default: asm_state_d = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_done_q   <= 1'b0;
            asm_state_q <= WAIT_HI;
            hi_byte_q   <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_done_q   <= rx_done_d;
            asm_state_q <= asm_state_d;
            hi_byte_q   <= hi_byte_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (resp),
        .TX      (TX),
        .tx_done (tx_done)
    );

endmodule

// File: tb/tb_cmd_uart_responder.sv
// Bench for cmd_uart_responder: a byte-level UART model drives RX and tracks the expected
// command, ready flag and frame errors; TX frames are sampled mid-bit.
module tb_cmd_uart_responder;
    import knights_uart_pkg::*;

    localparam int BD  = 16;
    localparam int BTO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int fe_seen = 0;

    // Byte-level reference model of the receive side.
    bit          m_have_hi = 1'b0;
    logic [7:0]  m_hi = 8'h00;
    logic [15:0] m_cmd = 16'h0000;
    logic        m_rdy = 1'b0;
    int          m_fe = 0;

    cmd_uart_responder #(
        .BAUD_DIV (BD),
        .BYTE_TO  (BTO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_cmd"}, cmd, m_cmd);
        checkOutput({tag, "_rdy"}, {15'd0, cmd_rdy}, {15'd0, m_rdy});
        checkOutput({tag, "_fe"}, 16'(fe_seen), 16'(m_fe));
    endtask

    // Idles gap_bits bit periods, then sends one frame; a gap of 5+ bits after a
    // high byte exceeds the 4-bit timeout and the model drops that byte.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        RX = 1'b1;
        repeat (gap_bits * BD) @(negedge clk);
        if (m_have_hi && gap_bits >= 5) m_have_hi = 1'b0;
        if (!m_have_hi) m_rdy = 1'b0;
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop_ok;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        if (!stop_ok) begin
            m_fe++;
        end else if (!m_have_hi) begin
            m_hi = b;
            m_have_hi = 1'b1;
        end else begin
            m_cmd = {m_hi, b};
            m_rdy = 1'b1;
            m_have_hi = 1'b0;
        end
    endtask

    task automatic pulseClear();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
    endtask

    initial begin
        logic [9:0]  frame;
        logic [7:0]  rb;
        int          gap;
        bit          ok;
        bit          prev_err;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", {15'd0, TX}, 16'd1);
        checkOutput("rst_cmd", cmd, 16'h0000);
        checkOutput("rst_rdy", {15'd0, cmd_rdy}, 16'd0);
        checkOutput("rst_txdone", {15'd0, tx_done}, 16'd0);
        checkOutput("rst_fe", {15'd0, frame_err}, 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] step 1: single command and clear");
        applyStimulus(8'h20, 1'b1, 2);
        applyStimulus(8'h00, 1'b1, 0);
        checkOutput("t1_cmd", cmd, 16'h2000);
        checkOutput("t1_rdy", {15'd0, cmd_rdy}, 16'd1);
        pulseClear();
        checkOutput("t1_clr", {15'd0, cmd_rdy}, 16'd0);

        $display("[TB] step 2: back-to-back pairs");
        applyStimulus(8'h60, 1'b1, 1);
        applyStimulus(8'h00, 1'b1, 0);
        checkModel("t2a");
        checkOutput("t2_cmd6000", cmd, 16'h6000);
        fork
            applyStimulus(8'h41, 1'b1, 0);
            begin
                repeat (6) @(negedge clk);
                checkOutput("t2_stale_clr", {15'd0, cmd_rdy}, 16'd0);
                checkOutput("t2_cmd_hold", cmd, 16'h6000);
            end
        join
        applyStimulus(8'h23, 1'b1, 0);
        checkModel("t2b");
        checkOutput("t2_cmd4123", cmd, 16'h4123);

        $display("[TB] step 3: low-byte timeout");
        applyStimulus(8'h60, 1'b1, 1);
        applyStimulus(8'h12, 1'b1, 5);
        checkModel("t3a");
        applyStimulus(8'h34, 1'b1, 0);
        checkModel("t3b");
        checkOutput("t3_cmd1234", cmd, 16'h1234);

        $display("[TB] step 4: framing error");
        applyStimulus(8'h55, 1'b0, 1);
        checkModel("t4a");
        applyStimulus(8'hAB, 1'b1, 2);
        applyStimulus(8'hCD, 1'b1, 0);
        checkModel("t4b");
        checkOutput("t4_cmdABCD", cmd, 16'hABCD);

        $display("[TB] step 5: start glitch");
        pulseClear();
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BD) @(negedge clk);
        checkModel("t5a");
        applyStimulus(8'h9A, 1'b1, 1);
        applyStimulus(8'hBC, 1'b1, 0);
        checkModel("t5b");

        $display("[TB] randomized byte stream");
        prev_err = 1'b0;
        for (int n = 0; n < 12; n++) begin
            rb  = 8'($urandom);
            gap = ($urandom_range(0, 3) == 0) ? 6 : int'($urandom_range(0, 1));
            ok  = !(!m_have_hi && $urandom_range(0, 4) == 0);
            if (prev_err && gap < 1) gap = 1;
            if ($urandom_range(0, 3) == 0) pulseClear();
            applyStimulus(rb, ok, gap);
            checkModel($sformatf("rnd%0d", n));
            prev_err = !ok;
        end

        $display("[TB] step 6: response transmit");
        repeat (4) @(negedge clk);
        checkOutput("t6_idle_tx", {15'd0, TX}, 16'd1);
        resp  = RESP_ACK;
        frame = {1'b1, RESP_ACK, 1'b0};
        trmt  = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        for (int idx = 0; idx <= 160; idx++) begin
            if (idx == 40) begin
                resp = 8'h00;
                trmt = 1'b1;
            end
            if (idx == 41) begin
                trmt = 1'b0;
                resp = RESP_ACK;
            end
            if (idx % BD == BD / 2) begin
                checkOutput($sformatf("t6_bit%0d", idx / BD), {15'd0, TX}, {15'd0, frame[idx / BD]});
            end
            if (idx == 0 || idx == 80 || idx == 159) begin
                checkOutput($sformatf("t6_done_low%0d", idx), {15'd0, tx_done}, 16'd0);
            end
            if (idx == 160) begin
                checkOutput("t6_done_set", {15'd0, tx_done}, 16'd1);
            end
            if (idx < 160) @(negedge clk);
        end

        $display("[TB] step 6b: reset mid-frame");
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_tx", {15'd0, TX}, 16'd1);
        checkOutput("t6_rst_done", {15'd0, tx_done}, 16'd0);
        checkOutput("t6_rst_cmd", cmd, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t6_post_tx", {15'd0, TX}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
